// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, immediate extension and the register hazard match.
package decode_pkg;

  typedef enum logic [5:0] {
    OP_J    = 6'h02,
    OP_BEQ  = 6'h04,
    OP_BNE  = 6'h05,
    OP_ANDI = 6'h0C,
    OP_ORI  = 6'h0D,
    OP_XORI = 6'h0E,
    OP_LUI  = 6'h0F
  } opcode_t;

  // The 32-bit result is always sign-extended by the caller; zero-extended forms keep bit 31 clear.
  function automatic logic [31:0] imm_ext32(input logic [5:0] op, input logic [15:0] imm);
    logic [31:0] r;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: r = {16'h0000, imm};
      OP_LUI:                   r = {imm, 16'h0000};
      default:                  r = {{16{imm[15]}}, imm};
    endcase
    return r;
  endfunction

  function automatic logic hz_match(input int unsigned rd, input int unsigned rs, input int unsigned rt);
    return (rd != 0) && ((rd == rs) || (rd == rt));
  endfunction

endpackage

// File: rtl/decode_if.sv
// Pipeline-side bundle of the decode stage: IF/ID inputs, EX/MEM/WB sideband, debug and ID/EX outputs.
interface decode_if #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int CTRL_W = 12
);
  localparam int AW = $clog2(NREG);

  logic              if_valid;
  logic [XLEN-1:0]   if_pc;
  logic [31:0]       if_instr;
  logic [CTRL_W-1:0] ctrl_word;
  logic              ex_mem_read, ex_reg_write;
  logic [AW-1:0]     ex_rd;
  logic              mem_mem_read, mem_reg_write;
  logic [AW-1:0]     mem_rd;
  logic [XLEN-1:0]   mem_alu_data;
  logic              wb_we;
  logic [AW-1:0]     wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              hold, dbg_en;
  logic [AW-1:0]     dbg_addr;
  logic [XLEN-1:0]   dbg_data;
  logic              pc_write, ifid_write, redirect;
  logic [XLEN-1:0]   redirect_pc;
  logic              id_valid;
  logic [CTRL_W-1:0] id_ctrl;
  logic [XLEN-1:0]   id_pc, id_rs_val, id_rt_val, id_imm;
  logic [AW-1:0]     id_rs, id_rt, id_rd;
  logic [5:0]        id_opcode;
  logic [31:0]       stall_count;

  modport master (
    output if_valid, if_pc, if_instr, ctrl_word, ex_mem_read, ex_reg_write, ex_rd,
           mem_mem_read, mem_reg_write, mem_rd, mem_alu_data, wb_we, wb_addr, wb_data,
           hold, dbg_en, dbg_addr,
    input  dbg_data, pc_write, ifid_write, redirect, redirect_pc, id_valid, id_ctrl, id_pc,
           id_rs_val, id_rt_val, id_imm, id_rs, id_rt, id_rd, id_opcode, stall_count
  );

  modport slave (
    input  if_valid, if_pc, if_instr, ctrl_word, ex_mem_read, ex_reg_write, ex_rd,
           mem_mem_read, mem_reg_write, mem_rd, mem_alu_data, wb_we, wb_addr, wb_data,
           hold, dbg_en, dbg_addr,
    output dbg_data, pc_write, ifid_write, redirect, redirect_pc, id_valid, id_ctrl, id_pc,
           id_rs_val, id_rt_val, id_imm, id_rs, id_rt, id_rd, id_opcode, stall_count
  );
endinterface

// File: rtl/decode_regfile.sv
// NREG x XLEN register file: two combinational read ports plus debug port, write-first bypass.
// r0 reads as zero; a blocked write is neither stored nor bypassed.
module decode_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic            i_wr_block,
  input  logic [AW-1:0]   i_ra1,
  input  logic [AW-1:0]   i_ra2,
  input  logic [AW-1:0]   i_dbg_addr,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2,
  output logic [XLEN-1:0] o_dbg_rd
);
  logic [XLEN-1:0] r_regs [NREG];
  logic            w_wr_en;

  assign w_wr_en = i_we && !i_wr_block && (i_waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rd1    = (i_ra1 == '0) ? '0 : (w_wr_en && i_ra1 == i_waddr) ? i_wdata : r_regs[i_ra1];
  assign o_rd2    = (i_ra2 == '0) ? '0 : (w_wr_en && i_ra2 == i_waddr) ? i_wdata : r_regs[i_ra2];
  assign o_dbg_rd = (i_dbg_addr == '0) ? '0 :
                    (w_wr_en && i_dbg_addr == i_waddr) ? i_wdata : r_regs[i_dbg_addr];
endmodule

// File: rtl/decode_stage.sv
// ID stage: register read, load-use/branch hazard stall, branch/jump resolution, ID/EX payload register.
// ID/EX is one cycle behind IF/ID; pc_write/ifid_write/redirect are combinational; hold freezes all state.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int CTRL_W = 12
) (
  input logic     clk,
  input logic     rst,
  decode_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [5:0]        w_op;
  logic [AW-1:0]     w_rs, w_rt, w_rd;
  logic [31:0]       w_imm32;
  logic [XLEN-1:0]   w_imm, w_rs_val, w_rt_val, w_dbg, w_cmp_a, w_cmp_b;
  logic [XLEN-1:0]   w_pc4, w_br_tgt, w_j_tgt;
  logic              w_is_br, w_load_use, w_br_haz, w_stall, w_issue, w_taken, w_fwd_a, w_fwd_b;

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [XLEN-1:0]   r_pc, r_rs_val, r_rt_val, r_imm;
  logic [AW-1:0]     r_rs, r_rt, r_rd;
  logic [5:0]        r_op;
  logic [31:0]       r_stall_cnt;

  assign w_op    = bus.if_instr[31:26];
  assign w_rs    = AW'(bus.if_instr[25:21]);
  assign w_rt    = AW'(bus.if_instr[20:16]);
  assign w_rd    = AW'(bus.if_instr[15:11]);
  assign w_imm32 = imm_ext32(w_op, bus.if_instr[15:0]);
  assign w_imm   = XLEN'($signed(w_imm32));

  decode_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_we       (bus.wb_we),
    .i_waddr    (bus.wb_addr),
    .i_wdata    (bus.wb_data),
    .i_wr_block (bus.dbg_en),
    .i_ra1      (w_rs),
    .i_ra2      (w_rt),
    .i_dbg_addr (bus.dbg_addr),
    .o_rd1      (w_rs_val),
    .o_rd2      (w_rt_val),
    .o_dbg_rd   (w_dbg)
  );
  assign bus.dbg_data = w_dbg;

  // A load in EX feeding a branch stalls here, then again as mem_mem_read: two bubbles.
  assign w_is_br    = (w_op == OP_BEQ) || (w_op == OP_BNE);
  assign w_load_use = bus.ex_mem_read && hz_match(32'(bus.ex_rd), 32'(w_rs), 32'(w_rt));
  assign w_br_haz   = w_is_br &&
                      ((bus.ex_reg_write && hz_match(32'(bus.ex_rd), 32'(w_rs), 32'(w_rt))) ||
                       (bus.mem_mem_read && hz_match(32'(bus.mem_rd), 32'(w_rs), 32'(w_rt))));
  assign w_stall    = !rst && bus.if_valid && (w_load_use || w_br_haz);
  assign w_issue    = bus.if_valid && !w_stall;

  assign w_fwd_a = bus.mem_reg_write && !bus.mem_mem_read && (bus.mem_rd != '0) && (bus.mem_rd == w_rs);
  assign w_fwd_b = bus.mem_reg_write && !bus.mem_mem_read && (bus.mem_rd != '0) && (bus.mem_rd == w_rt);
  assign w_cmp_a = w_fwd_a ? bus.mem_alu_data : w_rs_val;
  assign w_cmp_b = w_fwd_b ? bus.mem_alu_data : w_rt_val;

  assign w_pc4    = bus.if_pc + XLEN'(4);
  assign w_br_tgt = w_pc4 + (w_imm << 2);
  assign w_j_tgt  = {w_pc4[XLEN-1:28], bus.if_instr[25:0], 2'b00};
  assign w_taken  = (w_op == OP_J) ||
                    ((w_op == OP_BEQ) && (w_cmp_a == w_cmp_b)) ||
                    ((w_op == OP_BNE) && (w_cmp_a != w_cmp_b));

  assign bus.redirect    = !rst && !bus.hold && w_issue && w_taken;
  assign bus.redirect_pc = (w_op == OP_J) ? w_j_tgt : w_br_tgt;
  assign bus.pc_write    = rst || !(bus.hold || w_stall);
  assign bus.ifid_write  = rst || !(bus.hold || w_stall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_ctrl      <= '0;
      r_pc        <= '0;
      r_rs_val    <= '0;
      r_rt_val    <= '0;
      r_imm       <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_op        <= '0;
      r_stall_cnt <= '0;
    end else if (!bus.hold) begin
      r_valid  <= w_issue;
      r_ctrl   <= w_issue ? bus.ctrl_word : '0;
      r_pc     <= bus.if_pc;
      r_rs_val <= w_rs_val;
      r_rt_val <= w_rt_val;
      r_imm    <= w_imm;
      r_rs     <= w_rs;
      r_rt     <= w_rt;
      r_rd     <= w_rd;
      r_op     <= w_op;
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.id_valid    = r_valid;
  assign bus.id_ctrl     = r_ctrl;
  assign bus.id_pc       = r_pc;
  assign bus.id_rs_val   = r_rs_val;
  assign bus.id_rt_val   = r_rt_val;
  assign bus.id_imm      = r_imm;
  assign bus.id_rs       = r_rs;
  assign bus.id_rt       = r_rt;
  assign bus.id_rd       = r_rd;
  assign bus.id_opcode   = r_op;
  assign bus.stall_count = r_stall_cnt;
endmodule
